// File: rtl/bjt_cmd_pkg.sv
// Shared constants, state encodings and frame payload type for the BJT tracer
// host-command receiver.
package bjt_cmd_pkg;

  localparam logic [7:0] HDR_BYTE       = 8'hA5;

  localparam logic [7:0] CMD_SET_VSTART = 8'h01;
  localparam logic [7:0] CMD_SET_VSTOP  = 8'h02;
  localparam logic [7:0] CMD_SET_VSTEP  = 8'h03;
  localparam logic [7:0] CMD_START      = 8'h04;
  localparam logic [7:0] CMD_ABORT      = 8'h05;

  localparam logic [15:0] VSTART_RST    = 16'h0000;
  localparam logic [15:0] VSTOP_RST     = 16'hFFFF;
  localparam logic [15:0] VSTEP_RST     = 16'h0001;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    PS_HUNT,
    PS_CMD,
    PS_DHI,
    PS_DLO,
    PS_CHK
  } parse_state_e;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] data;
  } cmd_frame_t;

  // Expected CHK byte for a collected command/data pair.
  function automatic logic [7:0] frame_chk(input cmd_frame_t f);
    return f.cmd ^ f.data[15:8] ^ f.data[7:0];
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, edge-triggered start detect,
// mid-bit sampling; flags a low stop bit as a framing error.
module uart_rx_byte
  import bjt_cmd_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic       sync1_q, sync2_q, prev_q;
  logic [1:0] fill_q;
  logic       fall_c;

  // prev_q only reports "high" once sync2_q carries a real line sample, so a
  // line held low through reset never looks like a start edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      fill_q  <= {fill_q[0], 1'b1};
      prev_q  <= fill_q[1] & sync2_q;
    end
  end

  assign fall_c = fill_q[1] & prev_q & ~sync2_q;

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall_c) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {sync2_q, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shreg_q;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_valid_o = valid_q;
  assign byte_data_o  = data_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/bjt_cmd_rx.sv
// Host-command receiver: parses 5-byte A5 frames from the UART and drives the
// sweep configuration registers and start/abort strobes.
module bjt_cmd_rx
  import bjt_cmd_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 115200,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        globalclock,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic        busy,
  output logic [15:0] vstart,
  output logic [15:0] vstop,
  output logic [15:0] vstep,
  output logic        sweep_start,
  output logic        sweep_abort,
  output logic        cmd_ok,
  output logic        cmd_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W         = $clog2(TO_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TO_CYCLES - 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk_i        (globalclock),
    .rst_i        (rst),
    .rx_i         (uart_rx),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .frame_err_o  (frame_err)
  );

  parse_state_e    pstate_q, pstate_d;
  cmd_frame_t      frame_q, frame_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [15:0]     vstart_q, vstart_d;
  logic [15:0]     vstop_q, vstop_d;
  logic [15:0]     vstep_q, vstep_d;
  logic            start_q, start_d;
  logic            abort_q, abort_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;

  always_ff @(posedge globalclock) begin
    if (rst) begin
      pstate_q <= PS_HUNT;
      frame_q  <= '0;
      to_cnt_q <= '0;
      vstart_q <= VSTART_RST;
      vstop_q  <= VSTOP_RST;
      vstep_q  <= VSTEP_RST;
      start_q  <= 1'b0;
      abort_q  <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      frame_q  <= frame_d;
      to_cnt_q <= to_cnt_d;
      vstart_q <= vstart_d;
      vstop_q  <= vstop_d;
      vstep_q  <= vstep_d;
      start_q  <= start_d;
      abort_q  <= abort_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
    end
  end

  // A received byte takes priority over a timeout expiring in the same cycle.
  always_comb begin
    pstate_d = pstate_q;
    frame_d  = frame_q;
    to_cnt_d = to_cnt_q;
    vstart_d = vstart_q;
    vstop_d  = vstop_q;
    vstep_d  = vstep_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    if (byte_valid) begin
      to_cnt_d = '0;
      case (pstate_q)
        PS_HUNT: if (byte_data == HDR_BYTE) pstate_d = PS_CMD;
        PS_CMD: begin
          frame_d.cmd = byte_data;
          pstate_d    = PS_DHI;
        end
        PS_DHI: begin
          frame_d.data[15:8] = byte_data;
          pstate_d           = PS_DLO;
        end
        PS_DLO: begin
          frame_d.data[7:0] = byte_data;
          pstate_d          = PS_CHK;
        end
        PS_CHK: begin
          pstate_d = PS_HUNT;
          if (byte_data != frame_chk(frame_q)) begin
            err_d = 1'b1;
          end else begin
            case (frame_q.cmd)
              CMD_SET_VSTART: begin
                if (busy) err_d = 1'b1;
                else begin
                  vstart_d = frame_q.data;
                  ok_d     = 1'b1;
                end
              end
              CMD_SET_VSTOP: begin
                if (busy) err_d = 1'b1;
                else begin
                  vstop_d = frame_q.data;
                  ok_d    = 1'b1;
                end
              end
              CMD_SET_VSTEP: begin
                if (busy || frame_q.data == 16'h0000) err_d = 1'b1;
                else begin
                  vstep_d = frame_q.data;
                  ok_d    = 1'b1;
                end
              end
              CMD_START: begin
                if (busy || vstart_q > vstop_q) err_d = 1'b1;
                else begin
                  start_d = 1'b1;
                  ok_d    = 1'b1;
                end
              end
              CMD_ABORT: begin
                abort_d = 1'b1;
                ok_d    = 1'b1;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        default: pstate_d = PS_HUNT;
      endcase
    end else if (pstate_q != PS_HUNT) begin
      if (frame_err || to_cnt_q == TO_LAST) begin
        pstate_d = PS_HUNT;
        to_cnt_d = '0;
        err_d    = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  assign vstart      = vstart_q;
  assign vstop       = vstop_q;
  assign vstep       = vstep_q;
  assign sweep_start = start_q;
  assign sweep_abort = abort_q;
  assign cmd_ok      = ok_q;
  assign cmd_err     = err_q;

endmodule

// File: tb/tb_bjt_cmd_rx.sv
// Scoreboard bench for bjt_cmd_rx: serial stimulus with a frame-level
// reference model; a monitor checks every cmd_ok/cmd_err event.
module tb_bjt_cmd_rx;

  localparam int unsigned CLK_HZ       = 1_600_000;
  localparam int unsigned BAUD         = 100_000;
  localparam int unsigned TIMEOUT_BITS = 20;
  localparam int unsigned C            = CLK_HZ / BAUD;
  localparam int unsigned TO           = TIMEOUT_BITS * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        busy = 1'b0;
  logic [15:0] vstart, vstop, vstep;
  logic        sweep_start, sweep_abort, cmd_ok, cmd_err;

  always #5 clk = ~clk;

  bjt_cmd_rx #(
    .CLK_HZ       (CLK_HZ),
    .BAUD         (BAUD),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .globalclock (clk),
    .rst         (rst),
    .uart_rx     (uart_rx),
    .busy        (busy),
    .vstart      (vstart),
    .vstop       (vstop),
    .vstep       (vstep),
    .sweep_start (sweep_start),
    .sweep_abort (sweep_abort),
    .cmd_ok      (cmd_ok),
    .cmd_err     (cmd_err)
  );

  typedef struct {
    bit          ok, err, start, abort;
    logic [15:0] vstart, vstop, vstep;
    longint      lo, hi;
    int          tag;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          vectors = 0;
  int          miscompares = 0;
  longint      cyc = 0;
  int          tag_n = 0;
  int unsigned gap_max = 0;
  logic [15:0] m_vstart = 16'h0000;
  logic [15:0] m_vstop  = 16'hFFFF;
  logic [15:0] m_vstep  = 16'h0001;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cmd_ok/cmd_err cycle consumes one expected event.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (cmd_ok || cmd_err) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected event at cycle %0d: ok=%0b err=%0b start=%0b abort=%0b",
                   cyc, cmd_ok, cmd_err, sweep_start, sweep_abort);
        end else begin
          e = q.pop_front();
          if ({cmd_ok, cmd_err, sweep_start, sweep_abort} !== {e.ok, e.err, e.start, e.abort} ||
              vstart !== e.vstart || vstop !== e.vstop || vstep !== e.vstep ||
              cyc < e.lo || cyc > e.hi) begin
            miscompares++;
            $display("FAIL event %0d: got ok/err/start/abort=%b%b%b%b vstart=%h vstop=%h vstep=%h at cycle %0d; required %b%b%b%b vstart=%h vstop=%h vstep=%h in cycles %0d..%0d",
                     e.tag, cmd_ok, cmd_err, sweep_start, sweep_abort, vstart, vstop, vstep, cyc,
                     e.ok, e.err, e.start, e.abort, e.vstart, e.vstop, e.vstep, e.lo, e.hi);
          end
        end
      end else if (sweep_start || sweep_abort) begin
        vectors++;
        miscompares++;
        $display("FAIL stray strobe at cycle %0d: start=%0b abort=%0b without cmd_ok",
                 cyc, sweep_start, sweep_abort);
      end
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gap();
    if (gap_max != 0) idle($urandom_range(0, gap_max));
  endtask

  // One 8N1 character; called and returns on a falling clock edge.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    idle(C);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(C);
    end
    uart_rx = stop;
    idle(C);
    uart_rx = 1'b1;
  endtask

  task automatic push(input bit ok, input bit err, input bit st, input bit ab,
                      input longint lo, input longint hi);
    exp_t x;
    x.ok = ok; x.err = err; x.start = st; x.abort = ab;
    x.vstart = m_vstart; x.vstop = m_vstop; x.vstep = m_vstep;
    x.lo = lo; x.hi = hi; x.tag = tag_n;
    tag_n++;
    q.push_back(x);
  endtask

  // Command rules applied to a complete frame; updates the model registers.
  task automatic model_exec(input logic [7:0] cmd, input logic [15:0] data, input bit chk_good,
                            output bit ok, output bit st, output bit ab);
    ok = 0; st = 0; ab = 0;
    if (!chk_good) return;
    if (cmd == 8'h01 && !busy) begin m_vstart = data; ok = 1; end
    else if (cmd == 8'h02 && !busy) begin m_vstop = data; ok = 1; end
    else if (cmd == 8'h03 && !busy && data != 0) begin m_vstep = data; ok = 1; end
    else if (cmd == 8'h04 && !busy && m_vstart <= m_vstop) begin ok = 1; st = 1; end
    else if (cmd == 8'h05) begin ok = 1; ab = 1; end
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] dhi,
                            input logic [7:0] dlo, input logic [7:0] chk);
    bit ok, st, ab;
    send_byte(8'hA5, 1'b1); gap();
    send_byte(cmd, 1'b1);   gap();
    send_byte(dhi, 1'b1);   gap();
    send_byte(dlo, 1'b1);   gap();
    model_exec(cmd, {dhi, dlo}, chk == (cmd ^ dhi ^ dlo), ok, st, ab);
    push(ok, !ok, st, ab, cyc + 9 * C, cyc + 10 * C);
    send_byte(chk, 1'b1);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string when);
    check({when, " vstart"}, vstart, 16'h0000);
    check({when, " vstop"},  vstop,  16'hFFFF);
    check({when, " vstep"},  vstep,  16'h0001);
    check({when, " strobes"}, 16'({sweep_start, sweep_abort, cmd_ok, cmd_err}), 16'h0000);
  endtask

  initial begin
    logic [7:0]  cmd, dhi, dlo, chk, junk;
    logic [15:0] data;
    int unsigned r, nj;

    idle(4);
    check_reset_vals("reset");
    rst = 1'b0;
    idle(2 * C);

    // Directed frames
    send_frame(8'h01, 8'h01, 8'h23, 8'h23);
    send_frame(8'h02, 8'h12, 8'h34, 8'h00);
    send_frame(8'h02, 8'h12, 8'h34, 8'h24);
    send_frame(8'h01, 8'h01, 8'h00, 8'h00);
    send_frame(8'h02, 8'h02, 8'h00, 8'h00);
    send_frame(8'h04, 8'h00, 8'h00, 8'h04);
    busy = 1'b1;
    send_frame(8'h04, 8'h00, 8'h00, 8'h04);
    send_frame(8'h01, 8'h00, 8'h05, 8'h04);
    send_frame(8'h05, 8'h00, 8'h00, 8'h05);
    busy = 1'b0;
    send_frame(8'h03, 8'h00, 8'h00, 8'h03);
    send_frame(8'h03, 8'h00, 8'h10, 8'h13);
    send_frame(8'h01, 8'h03, 8'h00, 8'h02);
    send_frame(8'h04, 8'h00, 8'h00, 8'h04);
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    send_frame(8'h00, 8'h11, 8'h22, 8'h33);

    // Junk and a framing error while hunting are silent
    send_byte(8'h00, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h3C, 1'b0);
    idle(C);
    send_frame(8'h01, 8'h00, 8'h42, 8'h43);

    // Framing error on D_HI aborts the frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    push(0, 1, 0, 0, cyc + 9 * C, cyc + 10 * C);
    send_byte(8'h77, 1'b0);
    idle(C);
    send_frame(8'h02, 8'h80, 8'h00, 8'h82);

    // Timeout after a partial frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    push(0, 1, 0, 0, cyc + TO - C, cyc + TO + C);
    idle(25 * C);

    // Slow but in-time frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    idle(8 * C);
    send_byte(8'hF0, 1'b1);
    idle(8 * C);
    send_byte(8'h00, 1'b1);
    model_exec(8'h02, 16'hF000, 1, r[0], r[1], r[2]);
    push(1, 0, 0, 0, cyc + 9 * C, cyc + 10 * C);
    send_byte(8'hF2, 1'b1);

    // Randomised frames with junk, gaps, busy and corrupted checksums
    gap_max = 3 * C;
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    cmd = 8'h01;
        2:       cmd = 8'h02;
        3, 9:    cmd = 8'h03;
        4, 5:    cmd = 8'h04;
        6:       cmd = 8'h05;
        7:       cmd = 8'($urandom_range(6, 255));
        default: cmd = 8'h00;
      endcase
      if (cmd == 8'h01)      data = 16'($urandom_range(0, 16'h0400));
      else if (cmd == 8'h02) data = 16'($urandom_range(16'h0200, 16'hFFFF));
      else                   data = 16'($urandom_range(0, 16'hFFFF));
      if (r == 9) data = 16'h0000;
      dhi = data[15:8];
      dlo = data[7:0];
      chk = cmd ^ dhi ^ dlo;
      if ($urandom_range(0, 5) == 0) chk = chk ^ 8'(1 << $urandom_range(0, 7));
      nj = $urandom_range(0, 2);
      for (int j = 0; j < int'(nj); j++) begin
        junk = 8'($urandom_range(0, 255));
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk, 1'b1);
      end
      busy = ($urandom_range(0, 3) == 0);
      send_frame(cmd, dhi, dlo, chk);
      busy = 1'b0;
      gap();
    end
    gap_max = 0;

    // Reset mid-frame with the line held low across release
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    uart_rx = 1'b0;
    idle(3 * C);
    rst = 1'b1;
    idle(1);
    check_reset_vals("mid-byte reset");
    idle(1);
    rst = 1'b0;
    m_vstart = 16'h0000;
    m_vstop  = 16'hFFFF;
    m_vstep  = 16'h0001;
    idle(3 * C);
    uart_rx = 1'b1;
    idle(2 * C);
    check_reset_vals("after reset release");
    send_frame(8'h01, 8'hAB, 8'hCD, 8'h67);
    send_frame(8'h04, 8'h00, 8'h00, 8'h04);

    // Drain outstanding expectations, bounded
    for (int i = 0; i < int'(20 * C) && q.size() != 0; i++) idle(1);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain: %0d expected events never seen, required 0", q.size());
    end
    check("final vstart", vstart, m_vstart);
    check("final vstop",  vstop,  m_vstop);
    check("final vstep",  vstep,  m_vstep);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bjt_cmd_rx.md
# bjt_cmd_rx

Host-command receiver for the BJT curve tracer: deserialises 8N1 UART bytes from the PC, parses fixed 5-byte command frames, and drives the sweep configuration registers and start/abort strobes consumed by the DAC sweep controller. It is the upstream stage of the DAC/ADC/FIFO/UART-tx chain and closes the loop with the existing 115200-baud transmit path.

## Interface
- CLK_HZ, 50_000_000, input clock frequency
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults)
- TIMEOUT_BITS, 20, inter-byte timeout in bit periods
- globalclock  in  1  system clock, 50 MHz; the block's only clock
- rst  in  1  reset, synchronous, active-high
- uart_rx  in  1  asynchronous serial input, idle high
- busy  in  1  sweep in progress (from DAC controller)
- vstart  out  16  sweep start code; reset 0x0000
- vstop  out  16  sweep stop code; reset 0xFFFF
- vstep  out  16  sweep increment; reset 0x0001
- sweep_start  out  1  one-cycle start strobe; reset 0
- sweep_abort  out  1  one-cycle abort strobe; reset 0
- cmd_ok  out  1  one-cycle "frame accepted" pulse; reset 0
- cmd_err  out  1  one-cycle "frame rejected" pulse; reset 0

## Operation
- uart_rx passes a 2-flop synchroniser (both flops reset to 1).
- Byte receiver FSM: RX_IDLE -> RX_START on synchronised falling edge; RX_START waits CLKS_PER_BIT/2 cycles, returns to RX_IDLE if the line is high (glitch), else -> RX_DATA; RX_DATA samples 8 bits LSB-first, one every CLKS_PER_BIT cycles; RX_STOP samples stop bit: 1 -> byte_valid pulse with data; 0 -> framing error, byte discarded.
- Frame format: 0xA5, CMD, D_HI, D_LO, CHK, where CHK = CMD ^ D_HI ^ D_LO; data = {D_HI, D_LO}.
- Parser FSM: HUNT -> CMD -> DHI -> DLO -> CHK -> HUNT. In HUNT non-0xA5 bytes are dropped silently (no cmd_err).
- Execution on CHK byte with a matching checksum:
  - 0x01: vstart = data.
  - 0x02: vstop = data.
  - 0x03: vstep = data; data 0 rejected.
  - 0x04: sweep_start; rejected if busy or vstart > vstop (unsigned).
  - 0x05: sweep_abort; always accepted.
- Set commands (0x01-0x03) while busy are rejected; registers unchanged.
- Every accepted frame pulses cmd_ok. Every rejection pulses cmd_err: bad checksum, unknown CMD, rule violation, framing error outside HUNT, or timeout.
- Timeout: in any parser state other than HUNT, if TIMEOUT_BITS*CLKS_PER_BIT cycles pass since the last byte_valid, the parser returns to HUNT and pulses cmd_err.
- A framing error in HUNT is ignored silently. A framing error in any other state returns the parser to HUNT with cmd_err.

## Timing
- byte_valid asserts the cycle after the stop-bit sample.
- Register update and strobes (sweep_start/abort, cmd_ok/err) occur exactly 1 cycle after byte_valid of the CHK byte.
- All strobes are exactly one cycle wide. cmd_ok and cmd_err are never asserted together.
- busy is sampled in the same cycle as CHK byte_valid.
- rst overrides everything, including mid-byte and mid-frame. All outputs take their reset values the cycle after rst; both FSMs return to idle/HUNT.
- If the line is low when reset releases, no byte is received until the line goes high and then low again (edge-triggered start).
- A timeout expiring in the same cycle as byte_valid: the byte wins and the timeout counter reloads.
- Back-to-back frames with no idle gap are supported.

## Structure
- Shared package bjt_cmd_pkg holds:
  - header 0xA5;
  - opcodes CMD_SET_VSTART/VSTOP/VSTEP/START/ABORT;
  - reset defaults of vstart/vstop/vstep;
  - RX and parser state encodings.
- One sub-module, uart_rx_byte: synchroniser plus byte FSM, outputting byte_valid, byte_data and frame_err. Parser, timeout counter and registers stay in bjt_cmd_rx.

## Test plan
- Set vstart: send A5 01 01 23 23 -> vstart = 0x0123 and a single cmd_ok pulse, 1 cycle after the last byte_valid.
- Start: with vstart 0x0100, vstop 0x0200 and busy=0, send A5 04 00 00 04 -> one sweep_start and one cmd_ok pulse. Repeat with busy=1 -> cmd_err only, no sweep_start.
- Bad checksum: A5 02 12 34 00 -> cmd_err; vstop stays 0xFFFF. A following valid A5 02 12 34 24 -> vstop = 0x1234.
- Framing error: stop bit driven 0 on the D_HI byte -> cmd_err, parser returns to HUNT. Leading junk bytes 0x00 0x55 before a valid frame -> no cmd_err, frame accepted.
- Timeout: send A5 03, then idle for 20 bit times -> cmd_err, vstep unchanged. Assert rst mid-byte -> all outputs return to reset values and the next valid frame is accepted.
